// File: rtl/wave_burst_loader_pkg.sv
// Shared definitions for the procedural waveform burst loader: shape codes,
// FSM state encodings and the DW/AW defaults shared with the sample RAM wrapper.
package wave_burst_loader_pkg;

    localparam int DW_DEFAULT = 9;
    localparam int AW_DEFAULT = 11;

    typedef enum logic [1:0] {
        SHAPE_SQUARE = 2'd0,
        SHAPE_TRI    = 2'd1,
        SHAPE_SAW    = 2'd2,
        SHAPE_DC     = 2'd3
    } shape_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_BURST = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Periods longer than the RAM can hold are shortened to the full RAM.
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        return (len > max_len) ? max_len : len;
    endfunction

endpackage

// File: rtl/wave_burst_loader_if.sv
// Request/parameter and RAM-write bundle between a controller and the burst loader.
interface wave_burst_loader_if
    import wave_burst_loader_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) ();
    logic          start;
    logic [1:0]    shape;
    logic [3:0]    len_log2;
    logic [DW-1:0] amp;
    logic [DW-1:0] offset;
    logic          busy;
    logic          done;
    logic          wr;
    logic [DW-1:0] wdata;

    modport master (
        output start, shape, len_log2, amp, offset,
        input  busy, done, wr, wdata
    );

    modport slave (
        input  start, shape, len_log2, amp, offset,
        output busy, done, wr, wdata
    );
endinterface

// File: rtl/wave_shape_gen.sv
// Phase-to-sample mapping for the burst loader, registered once (the FILL stage).
// ph carries only the top DW+1 bits of the normalized AW-bit phase.
module wave_shape_gen
    import wave_burst_loader_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  shape_t        shape,
    input  logic [DW:0]   ph,
    input  logic          valid_in,
    input  logic          last_in,
    output logic [DW-1:0] u,
    output logic          valid,
    output logic          last
);
    logic [DW-1:0] u_next;

    always_comb begin
        u_next = '0;
        unique case (shape)
            SHAPE_SQUARE: u_next = ph[DW] ? '0 : '1;
            SHAPE_TRI:    u_next = ph[DW] ? ~ph[DW-1:0] : ph[DW-1:0];
            SHAPE_SAW:    u_next = ph[DW:1];
            SHAPE_DC:     u_next = '1;
            default:      u_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            u     <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
        end else begin
            u     <= u_next;
            valid <= valid_in;
            last  <= last_in;
        end
    end
endmodule

// File: rtl/wave_burst_loader.sv
// Procedural waveform writer: emits one period as a single gap-free RAM write burst.
// Define WAVE_OFFSET_EN to add a saturating DC-offset stage (one extra cycle of latency).
module wave_burst_loader
    import wave_burst_loader_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int AW = AW_DEFAULT
) (
    input logic                clk,
    input logic                rst,
    wave_burst_loader_if.slave bus
);
    localparam logic [3:0] AW_L = 4'(AW);

    state_t        state_reg, state_next;
    logic          accept;
    logic          busy_reg, done_reg;
    shape_t        shape_reg;
    logic [3:0]    len_reg;
    logic [DW-1:0] amp_reg;
    logic [AW-1:0] p_reg, last_p, ph;
    logic          gen_on_reg;
    logic [DW:0]   ph_top;
    logic [DW-1:0] u;
    logic          u_valid, u_last;
    logic [2*DW-1:0] product;
    logic [DW-1:0] scaled;
    logic          wr_reg, wr_last_reg;
    logic [DW-1:0] wdata_reg;

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        unique case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_FILL;
                end
            end
            ST_FILL:  state_next = ST_BURST;
            ST_BURST: if (wr_reg && wr_last_reg) state_next = ST_DONE;
            ST_DONE: begin
                // Back-to-back start is legal here: the done cycle is the idle gap.
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = ST_FILL;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == ST_FILL) || (state_next == ST_BURST);
            done_reg  <= (state_next == ST_DONE);
        end
    end

`ifdef WAVE_OFFSET_EN
    logic [DW-1:0] offset_reg;
`endif

    // Parameter latch and phase counter; p sweeps 0..N-1 once per accepted start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shape_reg  <= SHAPE_SQUARE;
            len_reg    <= '0;
            amp_reg    <= '0;
            p_reg      <= '0;
            gen_on_reg <= 1'b0;
`ifdef WAVE_OFFSET_EN
            offset_reg <= '0;
`endif
        end else if (accept) begin
            shape_reg  <= shape_t'(bus.shape);
            len_reg    <= clamp_len(bus.len_log2, AW_L);
            amp_reg    <= bus.amp;
            p_reg      <= '0;
            gen_on_reg <= 1'b1;
`ifdef WAVE_OFFSET_EN
            offset_reg <= bus.offset;
`endif
        end else if (gen_on_reg) begin
            if (p_reg == last_p) begin
                p_reg      <= '0;
                gen_on_reg <= 1'b0;
            end else begin
                p_reg <= p_reg + 1'b1;
            end
        end
    end

    assign last_p = ~({AW{1'b1}} << len_reg);
    assign ph     = p_reg << (AW_L - len_reg);
    assign ph_top = (DW+1)'(ph >> (AW - DW - 1));

    wave_shape_gen #(.DW(DW)) u_shape (
        .clk      (clk),
        .rst      (rst),
        .shape    (shape_reg),
        .ph       (ph_top),
        .valid_in (gen_on_reg),
        .last_in  (gen_on_reg && (p_reg == last_p)),
        .u        (u),
        .valid    (u_valid),
        .last     (u_last)
    );

    assign product = {{DW{1'b0}}, u} * {{DW{1'b0}}, amp_reg};
    assign scaled  = DW'(product >> DW);

`ifdef WAVE_OFFSET_EN
    logic [DW-1:0] s_reg;
    logic          s_valid, s_last;
    logic [DW:0]   sum;

    assign sum = {1'b0, s_reg} + {1'b0, offset_reg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_reg       <= '0;
            s_valid     <= 1'b0;
            s_last      <= 1'b0;
            wr_reg      <= 1'b0;
            wr_last_reg <= 1'b0;
            wdata_reg   <= '0;
        end else begin
            s_reg       <= scaled;
            s_valid     <= u_valid;
            s_last      <= u_last;
            wr_reg      <= s_valid;
            wr_last_reg <= s_last;
            wdata_reg   <= sum[DW] ? '1 : sum[DW-1:0];
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_reg      <= 1'b0;
            wr_last_reg <= 1'b0;
            wdata_reg   <= '0;
        end else begin
            wr_reg      <= u_valid;
            wr_last_reg <= u_last;
            wdata_reg   <= scaled;
        end
    end
`endif

    assign bus.busy  = busy_reg;
    assign bus.done  = done_reg;
    assign bus.wr    = wr_reg;
    assign bus.wdata = wdata_reg;
endmodule

// File: tb/tb_wave_burst_loader.sv
// Self-checking bench for wave_burst_loader: spec vectors, corner sequences and
// randomized bursts compared against an arithmetic waveform model.
module tb_wave_burst_loader;
    import wave_burst_loader_pkg::*;

`ifdef WAVE_OFFSET_EN
    localparam int LAT = 3;
    localparam int OFF_EN = 1;
`else
    localparam int LAT = 2;
    localparam int OFF_EN = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   got_q[$];

    always #5 clk = ~clk;

    wave_burst_loader_if #(.DW(9)) bus ();

    wave_burst_loader #(.DW(9), .AW(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int sh;
        int ln;
        int am;
        int of;
        int idx;
        int val;
    } vec_t;

    vec_t vecs[20];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Sample k of one period, from the waveform definitions in plain arithmetic.
    function automatic int model(input int sh, input int ln, input int am, input int of, input int k);
        int lc;
        int ph;
        int u;
        int s;
        lc = (ln > 11) ? 11 : ln;
        ph = k * (2048 >> lc);
        case (sh)
            0:       u = (ph < 1024) ? 511 : 0;
            1:       u = (ph < 1024) ? ph / 2 : 511 - (ph - 1024) / 2;
            2:       u = ph / 4;
            default: u = 511;
        endcase
        s = (u * am) / 512;
        if (OFF_EN != 0) begin
            s = s + of;
            if (s > 511) s = 511;
        end
        return s;
    endfunction

    // Starts at the current negedge; returns at the negedge where done is expected.
    task automatic run_burst(input int sh, input int ln, input int am, input int of, input int disturb_at);
        int e;
        int k;
        int n;
        int mism;
        n = 1 << ((ln > 11) ? 11 : ln);
        got_q.delete();
        bus.shape    = 2'(sh);
        bus.len_log2 = 4'(ln);
        bus.amp      = 9'(am);
        bus.offset   = 9'(of);
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_after_start", int'(bus.busy), 1);
        e = 1;
        while (!bus.wr && e < 8) begin
            @(negedge clk);
            e++;
        end
        check("wr_latency", e, LAT + 1);
        k = 0;
        while (bus.wr && k < 2100) begin
            got_q.push_back(int'(bus.wdata));
            if (k == disturb_at) begin
                bus.start    = 1'b1;
                bus.shape    = ~bus.shape;
                bus.len_log2 = bus.len_log2 + 4'd1;
                bus.amp      = ~bus.amp;
                bus.offset   = ~bus.offset;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        check("burst_len", k, n);
        check("done_after_burst", int'(bus.done), 1);
        check("busy_with_done", int'(bus.busy), 0);
        mism = 0;
        for (int i = 0; i < got_q.size(); i++)
            if (got_q[i] != model(sh, ln, am, of, i)) mism++;
        check("burst_data_mismatches", mism, 0);
        $display("burst shape=%0d len_log2=%0d amp=%0d offset=%0d samples=%0d data_errors=%0d",
                 sh, ln, am, of, k, mism);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int guard;
        int stray;

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.shape    = '0;
        bus.len_log2 = '0;
        bus.amp      = '0;
        bus.offset   = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_wr", int'(bus.wr), 0);
        check("reset_wdata", int'(bus.wdata), 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", int'(bus.busy), 0);

        vecs[0]  = '{2, 3, 511, 0, 0, 0};
        vecs[1]  = '{2, 3, 511, 0, 1, 63};
        vecs[2]  = '{2, 3, 511, 0, 2, 127};
        vecs[3]  = '{2, 3, 511, 0, 3, 191};
        vecs[4]  = '{2, 3, 511, 0, 4, 255};
        vecs[5]  = '{2, 3, 511, 0, 5, 319};
        vecs[6]  = '{2, 3, 511, 0, 6, 383};
        vecs[7]  = '{2, 3, 511, 0, 7, 447};
        vecs[8]  = '{0, 2, 256, 0, 0, 255};
        vecs[9]  = '{0, 2, 256, 0, 1, 255};
        vecs[10] = '{0, 2, 256, 0, 2, 0};
        vecs[11] = '{0, 2, 256, 0, 3, 0};
        vecs[12] = '{1, 11, 511, 0, 0, 0};
        vecs[13] = '{1, 11, 511, 0, 1023, 510};
        vecs[14] = '{1, 11, 511, 0, 1024, 510};
        vecs[15] = '{1, 11, 511, 0, 2047, 0};
        vecs[16] = '{3, 4, 511, 400, 0, (OFF_EN != 0) ? 511 : 510};
        vecs[17] = '{3, 4, 511, 0, 0, 510};
        vecs[18] = '{2, 15, 511, 0, 2047, 510};
        vecs[19] = '{0, 0, 300, 0, 0, 299};

        for (int i = 0; i < 20; i++) begin
            run_burst(vecs[i].sh, vecs[i].ln, vecs[i].am, vecs[i].of, -1);
            check($sformatf("vec%0d_sample%0d", i, vecs[i].idx),
                  (vecs[i].idx < got_q.size()) ? got_q[vecs[i].idx] : -1, vecs[i].val);
            @(negedge clk);
        end

        // start coincident with done is accepted
        run_burst(2, 3, 511, 0, -1);
        run_burst(0, 2, 256, 0, -1);
        @(negedge clk);

        // re-pulsed start and changed params mid-burst: no effect, single done
        run_burst(1, 4, 400, 50, 6);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.wr) stray++;
        end
        check("no_second_burst", stray, 0);

        // asynchronous reset in the middle of a 16-sample burst
        bus.shape    = 2'd2;
        bus.len_log2 = 4'd4;
        bus.amp      = 9'd511;
        bus.start    = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        k = 0;
        guard = 0;
        while (k < 5 && guard < 40) begin
            @(negedge clk);
            guard++;
            if (bus.wr) k++;
        end
        check("reached_sample5", k, 5);
        rst = 1'b1;
        #1;
        check("rst_mid_wr", int'(bus.wr), 0);
        check("rst_mid_busy", int'(bus.busy), 0);
        check("rst_mid_done", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_burst(2, 4, 511, 0, -1);
        @(negedge clk);

        for (int i = 0; i < 24; i++) begin
            run_burst(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 511)), int'($urandom_range(0, 511)), -1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
